// File: rtl/deint_pkg.sv
// Shared constants and types for the Ncbps=192 WiMax ping-pong block de-interleaver.
package deint_pkg;
  localparam int NCBPS  = 192;
  localparam int ROWS   = 16;
  localparam int COLS   = NCBPS / ROWS;
  localparam int ADDR_W = 8;

  localparam logic [3:0]        COL_LAST = 4'(COLS - 1);
  localparam logic [3:0]        ROW_LAST = 4'(ROWS - 1);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(NCBPS - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
  typedef enum logic       {BANK_A, BANK_B} bank_sel_t;
endpackage

// File: rtl/deint_bank.sv
// Simple dual-port 1 x 256 bit RAM; registered read, output held when not reading.
module deint_bank
  import deint_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic              i_wdata,
  input  logic              i_rden,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              o_q
);
  logic r_mem [0:(1<<ADDR_W)-1];
  logic r_q;

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  always_ff @(posedge clk)
    if (reset)       r_q <= 1'b0;
    else if (i_rden) r_q <= r_mem[i_raddr];

  assign o_q = r_q;
endmodule

// File: rtl/ppbuffer_deinterleaver.sv
// Ping-pong block de-interleaver: bits land at k = {col,row} in one bank while
// the other bank streams out in linear k order.
module ppbuffer_deinterleaver
  import deint_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic wrdata,
  input  logic valid_in,
  output logic ready_out,
  output logic q,
  output logic valid_out,
  input  logic ready_in,
  output logic block_done
);
  bank_state_t       r_state [2];
  bank_state_t       w_state_nxt [2];
  bank_sel_t         r_wptr, r_rptr, r_qsel;
  logic [3:0]        r_col, r_row;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_vld, r_last;
  logic              w_accept, w_rden, w_wlast, w_rlast;
  logic [ADDR_W-1:0] w_waddr;
  logic [1:0]        w_q;

  assign w_wlast = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_rlast = (r_raddr == K_LAST);
  assign w_waddr = {r_col, r_row};

  // Bank FSMs: state register
  always_ff @(posedge clk)
    if (reset) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end

  // Writer and reader never target the same bank, so both updates can apply.
  always_comb begin
    w_state_nxt = r_state;
    for (int b = 0; b < 2; b++) begin
      if (w_accept && r_wptr == bank_sel_t'(b))
        w_state_nxt[b] = w_wlast ? FULL : FILLING;
      if (w_rden && r_rptr == bank_sel_t'(b))
        w_state_nxt[b] = w_rlast ? EMPTY : DRAINING;
    end
  end

  always_comb begin
    ready_out = !reset && (r_state[r_wptr] == EMPTY || r_state[r_wptr] == FILLING);
    w_accept  = valid_in && ready_out;
    w_rden    = (r_state[r_rptr] == FULL || r_state[r_rptr] == DRAINING) &&
                (!r_vld || ready_in);
  end

  always_ff @(posedge clk)
    if (reset) begin
      r_wptr  <= BANK_A;
      r_rptr  <= BANK_A;
      r_qsel  <= BANK_A;
      r_col   <= '0;
      r_row   <= '0;
      r_raddr <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_wlast) begin
          r_col  <= '0;
          r_row  <= '0;
          r_wptr <= (r_wptr == BANK_A) ? BANK_B : BANK_A;
        end else if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
      if (w_rden) begin
        r_raddr <= w_rlast ? '0 : r_raddr + ADDR_W'(1);
        r_qsel  <= r_rptr;
        r_last  <= w_rlast;
        if (w_rlast) r_rptr <= (r_rptr == BANK_A) ? BANK_B : BANK_A;
      end
      if (w_rden)        r_vld <= 1'b1;
      else if (ready_in) r_vld <= 1'b0;
    end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    deint_bank u_bank (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_accept && r_wptr == bank_sel_t'(g)),
      .i_waddr (w_waddr),
      .i_wdata (wrdata),
      .i_rden  (w_rden && r_rptr == bank_sel_t'(g)),
      .i_raddr (r_raddr),
      .o_q     (w_q[g])
    );
  end

  assign q          = w_q[r_qsel];
  assign valid_out  = r_vld;
  assign block_done = !reset && r_vld && ready_in && r_last;
endmodule

// File: tb/tb_ppbuffer_deinterleaver.sv
// Randomized bench for ppbuffer_deinterleaver against a block-permutation reference model.
module tb_ppbuffer_deinterleaver;
  logic clk = 1'b0, reset = 1'b1, wrdata = 1'b0, valid_in = 1'b0, ready_in = 1'b0;
  logic ready_out, q, valid_out, block_done;

  ppbuffer_deinterleaver dut (
    .clk(clk), .reset(reset), .wrdata(wrdata), .valid_in(valid_in),
    .ready_out(ready_out), .q(q), .valid_out(valid_out),
    .ready_in(ready_in), .block_done(block_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: collect a block in arrival order, permute with
  // k = 16j - 191*floor(j/12), and queue the bits in output order.
  bit in_blk [192];
  bit tmp [192];
  bit expq [$];
  bit e;
  int wj = 0, outk = 0, cyc = 0, n_acc = 0, n_out = 0, n_done = 0;
  int last_in_cyc = -1, first_vld_cyc = -1;
  bit watch = 0, stall_watch = 0, have_prev = 0;
  int rdy_drops = 0, gaps = 0, q_changes = 0;
  logic q_prev;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      wj = 0; outk = 0; expq.delete();
    end else begin
      if (valid_out && ready_in) begin
        n_out++;
        if (expq.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          e = expq.pop_front();
          chk("q", int'(q), int'(e));
          chk("block_done", int'(block_done), int'(outk == 191));
          outk = (outk == 191) ? 0 : outk + 1;
        end
      end else if (block_done) chk("spurious_done", 1, 0);
      if (block_done) n_done++;
      if (valid_in && ready_out) begin
        in_blk[wj] = wrdata;
        n_acc++;
        if (wj == 191) begin
          for (int j = 0; j < 192; j++) tmp[16*j - 191*(j/12)] = in_blk[j];
          for (int k = 0; k < 192; k++) expq.push_back(tmp[k]);
          last_in_cyc = cyc;
          wj = 0;
        end else wj++;
      end
      if (valid_out && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (watch) begin
        if (valid_in && !ready_out) rdy_drops++;
        if (!valid_out && expq.size() > 0 && first_vld_cyc >= 0) gaps++;
      end
      if (stall_watch && valid_out) begin
        if (have_prev && q !== q_prev) q_changes++;
        q_prev = q; have_prev = 1;
      end
    end
  end

  int onehot = -1;

  task automatic drive(input int nbits, input int pv, input int pr, input int max_cyc,
                       output int got);
    int c = 0;
    int s = 0;
    while (s < nbits && c < max_cyc) begin
      valid_in = ($urandom_range(99) < pv);
      wrdata   = (onehot < 0) ? 1'($urandom) : 1'((s % 192) == onehot);
      ready_in = ($urandom_range(99) < pr);
      @(negedge clk);
      if (valid_in && ready_out) s++;
      @(posedge clk); #1;
      c++;
    end
    valid_in = 1'b0;
    got = s;
  endtask

  task automatic drain(input int pr, input int max_cyc);
    int c = 0;
    valid_in = 1'b0;
    while ((expq.size() > 0 || valid_out) && c < max_cyc) begin
      ready_in = ($urandom_range(99) < pr);
      @(posedge clk); #1;
      c++;
    end
    chk("drain_left", expq.size(), 0);
    ready_in = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_ready_out", int'(ready_out), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_block_done", int'(block_done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(ready_out), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, d0, o0, a0;
    int hot [3] = '{1, 12, 191};
    do_reset();

    // single set bit at j -> single set bit at k
    foreach (hot[i]) begin
      onehot = hot[i]; first_vld_cyc = -1; d0 = n_done;
      drive(192, 100, 100, 1000, got);
      chk("onehot_accepted", got, 192);
      drain(100, 1000);
      chk("onehot_latency", first_vld_cyc - last_in_cyc, 2);
      chk("onehot_done", n_done - d0, 1);
    end

    // random block, latency and single done pulse
    onehot = -1; first_vld_cyc = -1; d0 = n_done;
    drive(192, 100, 100, 1000, got);
    drain(100, 1000);
    chk("rand_latency", first_vld_cyc - last_in_cyc, 2);
    chk("rand_done", n_done - d0, 1);

    // back-to-back blocks at full rate
    first_vld_cyc = -1; rdy_drops = 0; gaps = 0; d0 = n_done; watch = 1;
    drive(768, 100, 100, 2000, got);
    drain(100, 1000);
    watch = 0;
    chk("b2b_accepted", got, 768);
    chk("b2b_ready_drops", rdy_drops, 0);
    chk("b2b_output_gaps", gaps, 0);
    chk("b2b_done", n_done - d0, 4);

    // downstream stall: two banks fill, then writer blocks with output held
    a0 = n_acc; d0 = n_done; q_changes = 0; have_prev = 0; stall_watch = 1;
    drive(1000, 100, 0, 500, got);
    stall_watch = 0;
    chk("bp_accepted", n_acc - a0, 384);
    chk("bp_valid_out", int'(valid_out), 1);
    chk("bp_ready_out", int'(ready_out), 0);
    chk("bp_q_stable", q_changes, 0);
    drain(100, 2000);
    chk("bp_done", n_done - d0, 2);

    // random valid/ready toggling
    d0 = n_done; o0 = n_out;
    drive(1920, 50, 50, 20000, got);
    chk("rnd_accepted", got, 1920);
    drain(50, 5000);
    chk("rnd_outputs", n_out - o0, 1920);
    chk("rnd_done", n_done - d0, 10);

    // reset mid-block with a bank stalled in draining
    drive(192, 100, 0, 1000, got);
    drive(100, 100, 0, 1000, got);
    do_reset();
    d0 = n_done; o0 = n_out;
    drive(192, 100, 100, 1000, got);
    drain(100, 1000);
    chk("post_rst_outputs", n_out - o0, 192);
    chk("post_rst_done", n_done - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ppbuffer_deinterleaver.md
Name: ppbuffer_deinterleaver

Overview:
- Receive-side counterpart of the transmit ping-pong interleaver buffer: a WiMax block de-interleaver for Ncbps = 192 (QPSK rate 1/2, s = 1).
- Accepts a serial stream of interleaved coded bits, writes each bit at its de-interleaved address into one of two 1-bit x 256 banks, and streams the restored order out of the other bank.
- Sits between the demodulator and the FEC decoder.
- Both sides use valid/ready handshakes.

Parameters:
- NCBPS, 192, coded bits per block.
- ROWS, 16, interleaver row count (fixed by the standard).
- COLS, NCBPS/ROWS = 12, columns per block.
- ADDR_W, 8, bank address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wrdata  in  1  interleaved input bit.
- valid_in  in  1  wrdata is valid.
- ready_out  out  1  block can accept wrdata this cycle.
- q  out  1  de-interleaved output bit.
- valid_out  out  1  q is valid.
- ready_in  in  1  downstream accepts q this cycle.
- block_done  out  1  one-cycle pulse when the last bit (k = 191) of a block is accepted downstream.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- Reset, sampled on a clk edge:
  - Both banks go EMPTY; all counters clear.
  - Write and read bank pointers go to A.
  - valid_out = 0, q = 0, block_done = 0.
  - ready_out = 0 while reset is high; it rises the first cycle after reset deasserts.
- A reset mid-block discards all buffered data; there is no partial output.
- Bank state per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING on the first accepted input bit.
  - FILLING -> FULL when input bit j = 191 is accepted.
  - FULL -> DRAINING on the first read issue.
  - DRAINING -> EMPTY when read address 191 is issued.
- Write side:
  - ready_out = 1 when the write-pointer bank is EMPTY or FILLING.
  - An input bit is accepted when valid_in && ready_out.
  - Input index j = 12*r + c, with column counter c (0..11) and row counter r (0..15).
  - On each accept, c increments; at c = 11, c wraps to 0 and r increments.
  - Write address k = 16*c + r, i.e. {c[3:0], r[3:0]}. This implements k = 16j - 191*floor(16j/192). No multipliers.
  - On accepting j = 191: counters clear, that bank goes FULL, and the write pointer toggles.
- Read side:
  - A read is issued (rden) when the read-pointer bank is FULL or DRAINING, and (!valid_out || ready_in).
  - The read address increments 0..191.
  - Banks have 1-cycle read latency, and q holds its value when rden = 0.
  - valid_out rises the cycle after an issue and stays high until accepted.
  - While valid_out && !ready_in, q and valid_out must remain stable.
  - Sustained throughput is 1 bit/clk.
  - After issuing address 191: that bank goes EMPTY and the read pointer toggles. block_done pulses when that final bit is handshaken.
- Latency: last input bit of a block accepted at edge N -> bank FULL after N -> first rden in cycle N+1 -> valid_out = 1 in cycle N+2.
- Simultaneous events:
  - A write completing into one bank and a read completing from the other in the same cycle: both transitions apply and both pointers toggle.
  - A bank freed (DRAINING -> EMPTY) while the writer is stalled: ready_out rises the next cycle.
- Both banks FULL or DRAINING with the writer pointing at a non-empty bank: ready_out = 0, and no input bit is lost or overwritten.
- valid_in while ready_out = 0 is ignored.

Decomposition:
- Package deint_pkg holds:
  - Constants NCBPS, ROWS, COLS, ADDR_W.
  - typedef enum bank_state_t {EMPTY, FILLING, FULL, DRAINING}.
  - typedef enum bank_sel_t {BANK_A, BANK_B}.
- One sub-module, deint_bank: simple dual-port 1 x 256 RAM, registered read with 1-cycle latency, q held when rden = 0. It is instantiated twice.
- Control (counters, bank FSMs, handshake, output mux) lives in the top.

Test Plan:
- Single block, ready_in = 1, input bit 1 at j = 1 only, all others 0 -> output bit 1 only at k = 16. Repeat with j = 12 -> k = 1, and j = 191 -> k = 191.
- Full permutation check: random 192-bit block vs. reference model k = 16j - 191*floor(j/12) -> all 192 output bits match. First valid_out occurs 2 cycles after the j = 191 accept, and block_done pulses once.
- Back-to-back: 4 blocks with continuous valid_in and ready_in = 1 -> ready_out never drops after the first block, output is continuous at 1 bit/clk, and each block is correct.
- Backpressure: ready_in = 0 for 500 cycles while driving input -> ready_out falls after 384 accepted bits, valid_out stays 1, and q stays stable. After ready_in rises, 384 bits drain correctly in order.
- Random ready_in/valid_in toggling (50%) over 10 blocks -> no loss, no duplication, and order correct.
- Reset asserted mid-block (after 100 inputs, with one bank draining) -> valid_out = 0 and ready_out = 0 during reset. The next full block after reset is output correctly, with no stale bits.
